ifmap_row_fetcher: RTL and testbench

Clocked PPE-side client for the IFMAP memory row protocol. For one PPE (PE_ID 5..9), it accepts the unsolicited first row that IFMAP memory pushes at each timestep start. It then issues one request packet per subsequent row, buffers returned 25-bit rows in a 2-entry FIFO, and presents them to the PPE datapath with a valid/ready handshake. It sits between the PPE's router port and its spike-input logic, and counts rows and timesteps so the PPE knows when a timestep's inputs are exhausted.

---
 rtl/ifmap_row_fetcher.sv | 187 ++++++++++++++++++
 tb/tb_ifmap_row_fetcher.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_row_fetcher.sv
// PPE-side client for the IFMAP memory row protocol: takes the pushed first row,
// requests the remaining rows one at a time, and buffers them in a 2-entry FIFO.
module ifmap_row_fetcher #(
   parameter int PE_ID        = 5,
   parameter int IMEM_ID      = 10,
   parameter int IFMAP_SIZE   = 25,
   parameter int ROWS_PER_TS  = 5,
   parameter int NUM_TS       = 2,
   parameter int OP_PPE_INPUT = 1,
   localparam int PKT_W       = IFMAP_SIZE + 8,
   localparam int IDX_W       = (ROWS_PER_TS > 1) ? $clog2(ROWS_PER_TS) : 1,
   localparam int TS_W        = (NUM_TS > 1) ? $clog2(NUM_TS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   input  logic [PKT_W-1:0]      rx_packet,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [PKT_W-1:0]      tx_packet,
   output logic                  row_valid,
   input  logic                  row_ready,
   output logic [IFMAP_SIZE-1:0] row_data,
   output logic [IDX_W-1:0]      row_index,
   output logic [TS_W-1:0]       row_ts,
   output logic                  ts_done,
   output logic                  all_done,
   output logic                  err
);

   typedef enum logic [2:0] {
      ST_WAIT_FIRST = 3'd0,
      ST_REQ        = 3'd1,
      ST_WAIT_RESP  = 3'd2,
      ST_DRAIN      = 3'd3,
      ST_FINISHED   = 3'd4
   } state_t;

   typedef struct packed {
      logic [IFMAP_SIZE-1:0] data;
      logic [IDX_W-1:0]      idx;
      logic [TS_W-1:0]       ts;
   } entry_t;

   localparam logic [PKT_W-1:0] REQ_PKT = {4'(IMEM_ID), 4'(PE_ID), {IFMAP_SIZE{1'b0}}};

   state_t           state_r, state_s;
   logic [1:0]       count_r, count_s;
   logic [IDX_W-1:0] rows_rx_r, rows_rx_s;
   logic [TS_W-1:0]  ts_r, ts_s;
   entry_t           head_r, tail_r, new_entry_s;
   logic             tx_valid_r, tx_valid_s;
   logic [PKT_W-1:0] tx_packet_r;
   logic             ts_done_r, ts_done_s;
   logic             all_done_r, all_done_s;
   logic             err_r;
   logic             rx_fire_s, pkt_ok_s, push_s, drop_s, pop_s, tx_fire_s;

   assign rx_ready  = (count_r != 2'd2);
   assign row_valid = (count_r != 2'd0);
   assign row_data  = head_r.data;
   assign row_index = head_r.idx;
   assign row_ts    = head_r.ts;
   assign tx_valid  = tx_valid_r;
   assign tx_packet = tx_packet_r;
   assign ts_done   = ts_done_r;
   assign all_done  = all_done_r;
   assign err       = err_r;

   // Handshake decode and FIFO occupancy update
   always_comb begin
      rx_fire_s   = rx_valid && rx_ready;
      pkt_ok_s    = (rx_packet[PKT_W-1 -: 4] == 4'(PE_ID)) &&
                    (rx_packet[PKT_W-5 -: 4] == 4'(OP_PPE_INPUT));
      push_s      = rx_fire_s && pkt_ok_s &&
                    ((state_r == ST_WAIT_FIRST) || (state_r == ST_WAIT_RESP));
      drop_s      = rx_fire_s && !push_s;
      pop_s       = row_valid && row_ready;
      tx_fire_s   = tx_valid_r && tx_ready;
      new_entry_s = '{data: rx_packet[IFMAP_SIZE-1:0], idx: rows_rx_r, ts: ts_r};
      case ({push_s, pop_s})
         2'b10:   count_s = count_r + 2'd1;
         2'b01:   count_s = count_r - 2'd1;
         default: count_s = count_r;
      endcase
   end

   // Next-state, counters and the request line
   always_comb begin
      state_s    = state_r;
      rows_rx_s  = rows_rx_r;
      ts_s       = ts_r;
      ts_done_s  = 1'b0;
      all_done_s = all_done_r;
      case (state_r)
         ST_WAIT_FIRST, ST_WAIT_RESP: begin
            if (push_s) begin
               rows_rx_s = rows_rx_r + IDX_W'(1);
               if (rows_rx_r == IDX_W'(ROWS_PER_TS - 1)) begin
                  state_s = ST_DRAIN;
               end else begin
                  state_s = ST_REQ;
               end
            end else begin
               state_s = state_r;
            end
         end
         ST_REQ: begin
            if (tx_fire_s) begin
               state_s = ST_WAIT_RESP;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_DRAIN: begin
            // No pushes happen here, so occupancy only falls until the timestep closes
            if (count_s == 2'd0) begin
               ts_done_s = 1'b1;
               rows_rx_s = '0;
               if (ts_r == TS_W'(NUM_TS - 1)) begin
                  state_s    = ST_FINISHED;
                  all_done_s = 1'b1;
               end else begin
                  ts_s    = ts_r + TS_W'(1);
                  state_s = ST_WAIT_FIRST;
               end
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_FINISHED: state_s = ST_FINISHED;
         default:     state_s = ST_WAIT_FIRST;
      endcase
      tx_valid_s = (state_s == ST_REQ) && (count_s != 2'd2);
   end

   // Control and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_WAIT_FIRST;
         count_r     <= 2'd0;
         rows_rx_r   <= '0;
         ts_r        <= '0;
         tx_valid_r  <= 1'b0;
         tx_packet_r <= '0;
         ts_done_r   <= 1'b0;
         all_done_r  <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         count_r     <= count_s;
         rows_rx_r   <= rows_rx_s;
         ts_r        <= ts_s;
         tx_valid_r  <= tx_valid_s;
         tx_packet_r <= tx_valid_s ? REQ_PKT : '0;
         ts_done_r   <= ts_done_s;
         all_done_r  <= all_done_s;
         err_r       <= drop_s;
      end
   end

   // Two-entry shift FIFO; head_r drives the row outputs directly
   always_ff @(posedge clk) begin
      if (reset) begin
         head_r <= '0;
         tail_r <= '0;
      end else begin
         case (count_r)
            2'd0: begin
               if (push_s) head_r <= new_entry_s;
            end
            2'd1: begin
               if (push_s && pop_s) head_r <= new_entry_s;
               else if (push_s)     tail_r <= new_entry_s;
            end
            2'd2: begin
               if (pop_s) head_r <= tail_r;
            end
            default: begin
               head_r <= head_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifmap_row_fetcher.sv
// Self-checking bench for ifmap_row_fetcher: bench acts as router and IFMAP memory,
// and a queue-based reference model predicts every output each cycle.
module tb_ifmap_row_fetcher;

   localparam int PE_ID = 5;
   localparam int IMEM_ID = 10;
   localparam int ROWS = 5;
   localparam int NTS = 2;
   localparam logic [32:0] REQ_PKT = 33'h1_4A00_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [32:0] rx_packet = 33'd0;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [32:0] tx_packet;
   logic        row_valid;
   logic        row_ready = 1'b0;
   logic [24:0] row_data;
   logic [2:0]  row_index;
   logic        row_ts;
   logic        ts_done;
   logic        all_done;
   logic        err;

   always #5 clk = ~clk;

   ifmap_row_fetcher dut (
      .clk(clk), .reset(reset),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_packet(rx_packet),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_packet(tx_packet),
      .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
      .row_index(row_index), .row_ts(row_ts),
      .ts_done(ts_done), .all_done(all_done), .err(err)
   );

   typedef struct packed {
      logic [24:0] d;
      logic [2:0]  i;
      logic        t;
   } row_t;

   // reference model: rows in flight, rows received this timestep, timestep
   row_t mq[$];
   int   m_got, m_ts, n_tx;
   bit   m_want, m_await, m_fin, m_err_p, m_tsd_p;

   // observed DUT events per scenario
   int n_dut_tx, n_dut_tsd, n_dut_pop, n_dut_err;
   int n_chk = 0;
   int n_pass = 0;

   // responder / stimulus controls
   int          rr_pct, tr_pct, resp_pct;
   bit          dmode, hold_resp, b_have, last_rx_fire;
   logic [32:0] b_pkt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic m_reset();
      mq.delete();
      m_got = 0; m_ts = 0; n_tx = 0;
      m_want = 1'b0; m_await = 1'b1; m_fin = 1'b0;
      m_err_p = 1'b0; m_tsd_p = 1'b0;
   endtask

   task automatic cycle();
      bit   e_rr, e_tv, e_rv, rx_f, tx_f, pop, ok;
      row_t h;
      @(negedge clk);
      e_rr = (mq.size() < 2);
      e_tv = m_want && (mq.size() < 2);
      e_rv = (mq.size() != 0);
      chk("rx_ready", rx_ready, e_rr);
      chk("tx_valid", tx_valid, e_tv);
      if (e_tv) chk("tx_packet", tx_packet, REQ_PKT);
      chk("row_valid", row_valid, e_rv);
      if (e_rv) begin
         h = mq[0];
         chk("row_data", row_data, h.d);
         chk("row_index", row_index, h.i);
         chk("row_ts", row_ts, h.t);
      end
      chk("ts_done", ts_done, m_tsd_p);
      chk("all_done", all_done, m_fin);
      chk("err", err, m_err_p);
      if (err === 1'b1) n_dut_err++;
      if (ts_done === 1'b1) n_dut_tsd++;
      if (tx_valid === 1'b1 && tx_ready) n_dut_tx++;
      if (row_valid === 1'b1 && row_ready) n_dut_pop++;
      rx_f = rx_valid && e_rr;
      tx_f = e_tv && tx_ready;
      pop  = e_rv && row_ready;
      last_rx_fire = rx_f;
      if (reset) begin
         m_reset();
      end else begin
         ok = (rx_packet[32:29] == 4'(PE_ID)) && (rx_packet[28:25] == 4'd1) && m_await;
         m_err_p = rx_f && !ok;
         m_tsd_p = 1'b0;
         if (pop) void'(mq.pop_front());
         if (rx_f && ok) begin
            h.d = rx_packet[24:0];
            h.i = 3'(m_got);
            h.t = 1'(m_ts);
            mq.push_back(h);
            m_got++;
            m_await = 1'b0;
            m_want = (m_got < ROWS);
         end
         if (tx_f) begin
            m_want = 1'b0;
            m_await = 1'b1;
            n_tx++;
         end
         if (m_got == ROWS && !m_fin && mq.size() == 0) begin
            m_tsd_p = 1'b1;
            m_got = 0;
            if (m_ts == NTS - 1) m_fin = 1'b1;
            else begin
               m_ts++;
               m_await = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      if (!hold_resp && m_await && !b_have && $urandom_range(99) < resp_pct) begin
         b_have = 1'b1;
         b_pkt[32:25] = {4'(PE_ID), 4'd1};
         if (dmode) b_pkt[24:0] = (m_got == 0) ? 25'h1FF_FFFF : (25'd1 << m_got);
         else       b_pkt[24:0] = 25'($urandom);
      end
      rx_valid  = b_have;
      rx_packet = b_have ? b_pkt : 33'd0;
      row_ready = ($urandom_range(99) < rr_pct);
      tx_ready  = ($urandom_range(99) < tr_pct);
      cycle();
      if (last_rx_fire) b_have = 1'b0;
   endtask

   task automatic inject(input logic [32:0] p);
      rx_valid  = 1'b1;
      rx_packet = p;
      row_ready = ($urandom_range(99) < rr_pct);
      tx_ready  = ($urandom_range(99) < tr_pct);
      cycle();
      rx_valid  = 1'b0;
      rx_packet = 33'd0;
   endtask

   function automatic bit cond(input int kind, input int target);
      case (kind)
         0:       return m_got >= target;
         1:       return n_dut_tsd >= target;
         2:       return m_await && (n_tx >= target);
         3:       return m_fin;
         default: return 1'b0;
      endcase
   endfunction

   task automatic run_until(input int kind, input int target, input int budget, input string tag);
      bit hit;
      for (int i = 0; i < budget; i++) begin
         if (cond(kind, target)) break;
         step();
      end
      hit = cond(kind, target);
      chk(tag, hit, 1'b1);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_rx_ready"}, rx_ready, 1'b1);
      chk({tag, "_tx_valid"}, tx_valid, 1'b0);
      chk({tag, "_tx_packet"}, tx_packet, 33'd0);
      chk({tag, "_row_valid"}, row_valid, 1'b0);
      chk({tag, "_row_data"}, row_data, 25'd0);
      chk({tag, "_row_index"}, row_index, 3'd0);
      chk({tag, "_row_ts"}, row_ts, 1'b0);
      chk({tag, "_ts_done"}, ts_done, 1'b0);
      chk({tag, "_all_done"}, all_done, 1'b0);
      chk({tag, "_err"}, err, 1'b0);
   endtask

   task automatic scen_reset(input string tag);
      reset = 1'b1; rx_valid = 1'b0; rx_packet = 33'd0;
      row_ready = 1'b0; tx_ready = 1'b0; b_have = 1'b0; hold_resp = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      m_reset();
      n_dut_tx = 0; n_dut_tsd = 0; n_dut_pop = 0; n_dut_err = 0;
      check_reset_vals(tag);
   endtask

   initial begin
      // A: single timestep, directed data, PPE always ready
      scen_reset("a_reset");
      rr_pct = 100; tr_pct = 100; resp_pct = 100; dmode = 1'b1;
      run_until(1, 1, 200, "a_ts_done_seen");
      chk("a_tx_count", n_dut_tx, 4);
      chk("a_rows_out", n_dut_pop, 5);

      // B: backpressure holds the FIFO full and blocks further requests
      scen_reset("b_reset");
      rr_pct = 0; dmode = 1'b0;
      repeat (20) step();
      chk("b_one_req", n_dut_tx, 1);
      chk("b_full_no_req", {row_valid, rx_ready, tx_valid}, 3'b100);
      rr_pct = 100;
      run_until(1, 1, 300, "b_resume_ts_done");
      chk("b_tx_total", n_dut_tx, 4);

      // C: tx stall keeps the request pending and unchanged
      scen_reset("c_reset");
      tr_pct = 0;
      repeat (12) step();
      chk("c_tx_held", {tx_valid, tx_packet}, {1'b1, REQ_PKT});
      chk("c_no_handshake", n_dut_tx, 0);
      tr_pct = 100;
      run_until(1, 1, 200, "c_ts_done");

      // D: junk packets in WAIT_RESP and during DRAIN
      scen_reset("d_reset");
      run_until(0, 1, 50, "d_first_row");
      hold_resp = 1'b1;
      run_until(2, 1, 50, "d_req_sent");
      inject({4'd6, 4'd1, 25'h0AB_CDEF});
      inject({4'(PE_ID), 4'd3, 25'h123_4567});
      step();
      chk("d_junk_err", n_dut_err, 2);
      hold_resp = 1'b0;
      run_until(0, 4, 100, "d_row4");
      rr_pct = 0;
      run_until(0, 5, 100, "d_row5");
      if (mq.size() == 2) begin
         rr_pct = 100;
         step();
         rr_pct = 0;
      end
      inject({4'(PE_ID), 4'd1, 25'h155_5555});
      step();
      chk("d_drain_err", n_dut_err, 3);
      rr_pct = 100;
      run_until(1, 1, 100, "d_ts_done");

      // E: two timesteps with random data and random handshakes
      scen_reset("e_reset");
      rr_pct = 70; tr_pct = 70; resp_pct = 60;
      run_until(3, 0, 3000, "e_finished");
      step();
      step();
      chk("e_ts_done_count", n_dut_tsd, 2);
      chk("e_all_done", all_done, 1'b1);
      chk("e_rows_out", n_dut_pop, 10);
      for (int k = 0; k < 3; k++) begin
         inject({4'(PE_ID), 4'd1, 25'($urandom)});
      end
      step();
      chk("e_post_err", n_dut_err, 3);
      chk("e_all_done_sticky", all_done, 1'b1);

      // F: reset mid-run with a request pending
      scen_reset("f_reset");
      rr_pct = 100; tr_pct = 100; resp_pct = 100;
      run_until(0, 2, 100, "f_two_rows");
      tr_pct = 0;
      repeat (3) step();
      chk("f_req_pending", tx_valid, 1'b1);
      reset = 1'b1; rx_valid = 1'b0; b_have = 1'b0;
      cycle();
      cycle();
      reset = 1'b0;
      check_reset_vals("f_after_reset");
      tr_pct = 100;
      run_until(0, 1, 50, "f_first_again");
      chk("f_first_index", {row_valid, row_index, row_ts}, {1'b1, 3'd0, 1'b0});
      run_until(1, 1, 200, "f_ts_done");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
